// File: rtl/pipelined_alu.sv
// pipelined_alu: registered ALU behind a valid/ready handshake.
// Single-cycle ops register on the accept edge; MUL runs a WIDTH-cycle
// signed shift-add engine. Status flags {C,L,F,Z,N} are held here so
// ADDC/SUBC see the carry of the previous operation.
//
// Opcode map (op[7:4] class, op[3:0] sub-op):
//   0x0_ RTYPE : 1 AND, 2 OR, 3 XOR, 5 ADD, 6 ADDU, 7 ADDC,
//                9 SUB, A SUBC, B CMP, D MOV, E MUL
//   0x10 ANDI, 0x20 ORI, 0x30 XORI, 0x50 ADDI, 0x60 ADDUI,
//   0x90 SUBI, 0xB0 CMPI, 0xD0 MOVI, 0xF0 LUI (immediate sub-op must be 0)
//   0x40 LOAD, 0x44 STORE
//   0x80 LSHI +1, 0x81 LSHI -1, 0x82 ASHUI +1, 0x83 ASHUI -1,
//   0x84 LSH, 0x85 STORI, 0x86 ASHU
// Anything else is illegal: result 0, flags untouched.
module pipelined_alu #(
  parameter int WIDTH   = 16,
  parameter int CTL_LEN = 8,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTL_LEN-1:0] op,
  input  logic [WIDTH-1:0]   src,
  input  logic [WIDTH-1:0]   dst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               illegal,
  output logic [4:0]         flags
);

  localparam int FC = 4;  // flag bit positions in {C,L,F,Z,N}
  localparam int CW = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_MUL  = 8'h0E;

  typedef enum logic [1:0] {IDLE, MUL_RUN, HOLD} st_t;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [4:0]       f;
    logic             ill;
  } exe_t;

  st_t st_q, st_d;
  logic rdy_q;
  logic acc_en;

  logic [3:0] cls, sub;
  logic [7:0] opc;

  // multiplier state
  logic [2*WIDTH-1:0] mcand, acc, pp, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last, mul_ovf;
  logic [WIDTH:MSB]   mul_hi;

  // single-cycle datapath
  logic               add_cin, sub_cin;
  logic [WIDTH:0]     add_w, sub_w;
  logic               add_ovf, sub_ovf;
  logic [SHAMT_W-1:0] amt, sh_mag;
  logic               sh_imm, sh_neg, sh_ari;
  logic [WIDTH:0]     shl, srl, sra;
  exe_t               ex;

  function automatic logic [1:0] zn(input logic [WIDTH-1:0] v);
    return {v == '0, v[MSB]};
  endfunction

  assign opc      = op[7:0];
  assign cls      = opc[7:4];
  assign sub      = opc[3:0];
  assign in_ready = rdy_q & (st_q == IDLE);
  assign out_valid = (st_q == HOLD);
  assign acc_en   = in_valid & in_ready;

  // add / subtract with optional stored carry
  assign add_cin = (opc == OP_ADDC) & flags[FC];
  assign sub_cin = (opc == OP_SUBC) & flags[FC];
  assign add_w   = {1'b0, dst} + {1'b0, src} + {{WIDTH{1'b0}}, add_cin};
  assign sub_w   = {1'b0, dst} - {1'b0, src} - {{WIDTH{1'b0}}, sub_cin};
  assign add_ovf = (dst[MSB] == src[MSB]) & (add_w[MSB] != dst[MSB]);
  assign sub_ovf = (dst[MSB] != src[MSB]) & (sub_w[MSB] != dst[MSB]);

  // shift controls: immediate forms shift by one, register forms use
  // the signed low bits of src (negative means shift right)
  assign amt    = src[SHAMT_W-1:0];
  assign sh_imm = (sub[3:2] == 2'b00);
  assign sh_ari = sub[1];
  assign sh_neg = sh_imm ? sub[0] : amt[SHAMT_W-1];
  assign sh_mag = sh_imm ? SHAMT_W'(1)
                : (amt[SHAMT_W-1] ? (~amt + SHAMT_W'(1)) : amt);

  // one extra bit on the outgoing side captures the last bit shifted out
  assign shl = {1'b0, dst} << sh_mag;
  assign srl = {dst, 1'b0} >> sh_mag;
  assign sra = $signed({dst, 1'b0}) >>> sh_mag;

  // one-cycle result, flags and illegal decode
  always_comb begin
    ex     = '0;
    ex.f   = flags;
    case (cls)
      4'h0: begin
        case (sub)
          4'h1: begin ex.r = dst & src; ex.f = {3'b000, zn(ex.r)}; end
          4'h2: begin ex.r = dst | src; ex.f = {3'b000, zn(ex.r)}; end
          4'h3: begin ex.r = dst ^ src; ex.f = {3'b000, zn(ex.r)}; end
          4'h5, 4'h7: begin
            ex.r = add_w[MSB:0];
            ex.f = {add_w[WIDTH], 1'b0, add_ovf, zn(ex.r)};
          end
          4'h6: begin
            ex.r = add_w[MSB:0];
            ex.f = {add_w[WIDTH], 2'b00, zn(ex.r)};
          end
          4'h9, 4'hA: begin
            ex.r = sub_w[MSB:0];
            ex.f = {sub_w[WIDTH], 1'b0, sub_ovf, zn(ex.r)};
          end
          4'hB: ex.f = {1'b0, dst < src, 1'b0, dst == src,
                        $signed(dst) < $signed(src)};
          4'hD: ex.r = dst;
          4'hE: ;  // MUL handled by the shift-add engine
          default: ex.ill = 1'b1;
        endcase
      end
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'hF: begin
        if (sub != 4'h0) begin
          ex.ill = 1'b1;
        end else begin
          case (cls)
            4'h1: begin ex.r = dst & src; ex.f = {3'b000, zn(ex.r)}; end
            4'h2: begin ex.r = dst | src; ex.f = {3'b000, zn(ex.r)}; end
            4'h3: begin ex.r = dst ^ src; ex.f = {3'b000, zn(ex.r)}; end
            4'h5: begin
              ex.r = add_w[MSB:0];
              ex.f = {add_w[WIDTH], 1'b0, add_ovf, zn(ex.r)};
            end
            4'h6: begin
              ex.r = add_w[MSB:0];
              ex.f = {add_w[WIDTH], 2'b00, zn(ex.r)};
            end
            4'h9: begin
              ex.r = sub_w[MSB:0];
              ex.f = {sub_w[WIDTH], 1'b0, sub_ovf, zn(ex.r)};
            end
            4'hB: ex.f = {1'b0, dst < src, 1'b0, dst == src,
                          $signed(dst) < $signed(src)};
            4'hD: ex.r = dst;
            default: ex.r = dst << (WIDTH / 2);  // LUI
          endcase
        end
      end
      4'h4: begin
        if (sub == 4'h0 || sub == 4'h4) ex.r = dst;
        else                            ex.ill = 1'b1;
      end
      4'h8: begin
        case (sub)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6: begin
            if (!sh_neg) begin
              ex.r = shl[MSB:0];
              ex.f = {shl[WIDTH], 2'b00, zn(ex.r)};
            end else if (sh_ari) begin
              ex.r = sra[WIDTH:1];
              ex.f = {sra[0], 2'b00, zn(ex.r)};
            end else begin
              ex.r = srl[WIDTH:1];
              ex.f = {srl[0], 2'b00, zn(ex.r)};
            end
          end
          4'h5: ex.r = src;  // STORI
          default: ex.ill = 1'b1;
        endcase
      end
      default: ex.ill = 1'b1;
    endcase
  end

  // shift-add step; the multiplier MSB carries negative weight, so the
  // final partial product is subtracted
  assign mul_last = (cnt == CW'(1));
  assign pp       = mplier[0] ? mcand : '0;
  assign acc_nx   = mul_last ? (acc - pp) : (acc + pp);
  assign mul_hi   = acc_nx[WIDTH:MSB];
  assign mul_ovf  = ~((&acc_nx[2*WIDTH-1:MSB]) | ~(|acc_nx[2*WIDTH-1:MSB]));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= IDLE;
    else          st_q <= st_d;
  end

  // next-state
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (acc_en) st_d = (opc == OP_MUL) ? MUL_RUN : HOLD;
      MUL_RUN: if (mul_last) st_d = HOLD;
      HOLD:    if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // in_ready stays low through reset and rises on the first clock after
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // result/flags registers and multiplier engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result  <= '0;
      illegal <= 1'b0;
      flags   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (st_q == IDLE && acc_en) begin
      if (opc == OP_MUL) begin
        mcand  <= {{WIDTH{dst[MSB]}}, dst};
        mplier <= src;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else begin
        result  <= ex.r;
        illegal <= ex.ill;
        flags   <= ex.f;
      end
    end else if (st_q == MUL_RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (mul_last) begin
        result  <= acc_nx[MSB:0];
        illegal <= 1'b0;
        flags   <= {2'b00, mul_ovf, zn(acc_nx[MSB:0])};
      end
    end
  end

  // mul_hi exists only for readability of the overflow window in waves
  logic unused_ok;
  assign unused_ok = ^mul_hi;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu: hand-computed vectors, latency,
// backpressure, reset mid-multiply and illegal opcode behaviour.
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [7:0]  op;
  logic [15:0] src, dst;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        illegal;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  pipelined_alu #(.WIDTH(16), .CTL_LEN(8), .SHAMT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src(src), .dst(dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // present an op at negedge, wait (bounded) for in_ready, transfer on posedge
  task automatic issue(input string tag, input logic [7:0] o, input logic [15:0] d, input logic [15:0] s);
    int n;
    @(negedge clk);
    op = o; dst = d; src = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".acc"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // full transaction: latency counted in edges from the accept edge
  task automatic run(input string tag, input logic [7:0] o, input logic [15:0] d,
                     input logic [15:0] s, input logic [15:0] er, input logic [4:0] ef,
                     input logic ei, input int elat);
    int lat, lo;
    issue(tag, o, d, s);
    lat = 1;
    lo  = (!in_ready && !out_valid) ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready && !out_valid) lo++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".busy"}, 32'(lo), 32'(elat - 1));
    chk({tag, ".r"}, 32'(result), 32'(er));
    chk({tag, ".f"}, 32'(flags), 32'(ef));
    chk({tag, ".ill"}, 32'(illegal), 32'(ei));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src = '0; dst = '0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst.rdy",  32'(in_ready),  32'd0);
    chk("rst.ov",   32'(out_valid), 32'd0);
    chk("rst.r",    32'(result),    32'd0);
    chk("rst.ill",  32'(illegal),   32'd0);
    chk("rst.f",    32'(flags),     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.rdy1", 32'(in_ready), 32'd1);

    //   tag     op     dst      src      result   flags {C,L,F,Z,N}  ill lat
    run("add",   8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1'b0, 1);
    run("addu",  8'h06, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 1'b0, 1);
    run("addc",  8'h07, 16'h0000, 16'h0000, 16'h0001, 5'b00000, 1'b0, 1);
    run("sub",   8'h09, 16'h0003, 16'h0005, 16'hFFFE, 5'b10001, 1'b0, 1);
    run("subc",  8'h0A, 16'h0005, 16'h0002, 16'h0002, 5'b00000, 1'b0, 1);
    run("addi",  8'h50, 16'h7000, 16'h7000, 16'hE000, 5'b00101, 1'b0, 1);
    run("xor",   8'h03, 16'hFF00, 16'h0FF0, 16'hF0F0, 5'b00001, 1'b0, 1);
    run("mov",   8'h0D, 16'h1234, 16'h0000, 16'h1234, 5'b00001, 1'b0, 1);
    run("lui",   8'hF0, 16'h00AB, 16'h0000, 16'hAB00, 5'b00001, 1'b0, 1);
    run("stori", 8'h85, 16'h0000, 16'h5A5A, 16'h5A5A, 5'b00001, 1'b0, 1);
    run("mul1",  8'h0E, 16'hFFFD, 16'h0007, 16'hFFEB, 5'b00001, 1'b0, 17);
    run("mul2",  8'h0E, 16'h4000, 16'h0004, 16'h0000, 5'b00110, 1'b0, 17);
    run("lsh_r", 8'h84, 16'h00F0, 16'hFFFC, 16'h000F, 5'b00000, 1'b0, 1);
    run("ashu",  8'h86, 16'h8000, 16'hFFF1, 16'hFFFF, 5'b00001, 1'b0, 1);
    run("lsh16", 8'h84, 16'h8001, 16'h0010, 16'h0000, 5'b10010, 1'b0, 1);
    run("lsh_l", 8'h84, 16'h8001, 16'h0001, 16'h0002, 5'b10000, 1'b0, 1);
    run("ashui", 8'h83, 16'h8003, 16'h0000, 16'hC001, 5'b10001, 1'b0, 1);

    // backpressure: CMP 5 vs 9 held while a second op waits
    issue("cmp", 8'h0B, 16'h0005, 16'h0009);
    chk("cmp.ov", 32'(out_valid), 32'd1);
    @(negedge clk);
    op = 8'h05; dst = 16'h0001; src = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.ov",  32'(out_valid), 32'd1);
      chk("bp.rdy", 32'(in_ready),  32'd0);
      chk("bp.r",   32'(result),    32'h0000);
      chk("bp.f",   32'(flags),     32'(5'b01001));
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("bp.rdy2", 32'(in_ready),  32'd1);
    chk("bp.ov2",  32'(out_valid), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("bp.next.ov", 32'(out_valid), 32'd1);
    chk("bp.next.r",  32'(result),    32'h0002);
    chk("bp.next.f",  32'(flags),     32'd0);
    drain();

    // leave nonzero flags, then reset in the middle of a multiply
    run("cmp2", 8'h0B, 16'h0005, 16'h0009, 16'h0000, 5'b01001, 1'b0, 1);
    issue("mulrst", 8'h0E, 16'h0003, 16'h0003);
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst.ov",  32'(out_valid), 32'd0);
    chk("mrst.f",   32'(flags),     32'd0);
    chk("mrst.rdy", 32'(in_ready),  32'd0);
    chk("mrst.r",   32'(result),    32'd0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst.rdy1", 32'(in_ready),  32'd1);
    chk("mrst.ov1",  32'(out_valid), 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst.stale", 32'(seen), 32'd0);

    // illegal opcode keeps flags from the previous op
    run("add2",  8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1'b0, 1);
    run("ill70", 8'h70, 16'h1234, 16'h5678, 16'h0000, 5'b00101, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
